uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enable sequencing, oversample tick generation and a
// show-ahead receive buffer with sticky overrun / framing-error flags.
module uart_rx_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_en,
    input  logic [DIV_W-1:0]         cfg_div,
    output logic                     rx_en_o,
    output logic                     os_tick_o,
    input  logic [DATA_W-1:0]        rx_byte_i,
    input  logic                     rx_vld_i,
    input  logic                     rx_ferr_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     rd_vld_o,
    input  logic                     rd_rdy_i,
    output logic [$clog2(DEPTH):0]   fifo_cnt_o,
    output logic                     ovr_err_o,
    output logic                     ferr_o,
    input  logic                     err_clr_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_DIS = 2'd0,
        ST_ARM = 2'd1,
        ST_RUN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic              rx_en_q, rx_en_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     fcnt_q, fcnt_d;
    logic              ovr_q, ovr_d;
    logic              ferr_q, ferr_d;

    logic              push_req, push, pop, full;

    // Sequencing FSM and divider; the tick is registered from the next count so
    // it lines up with the cycle in which the counter equals cfg_div.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_DIS: if (cfg_en) state_d = ST_ARM;
            ST_ARM: state_d = cfg_en ? ST_RUN : ST_DIS;
            ST_RUN: begin
                if (!cfg_en) begin
                    state_d = ST_DIS;
                end else if (cnt_q >= cfg_div) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = ST_DIS;
        endcase
        rx_en_d = (state_d == ST_RUN);
        tick_d  = (state_d == ST_RUN) && (cnt_d == cfg_div);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_DIS;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            rx_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            rx_en_q <= rx_en_d;
        end
    end

    // Buffer control: a full buffer still accepts a push when the head is popped.
    always_comb begin
        full     = (fcnt_q == CW'(DEPTH));
        pop      = rd_rdy_i && (fcnt_q != '0);
        push_req = rx_vld_i && !rx_ferr_i && (state_q != ST_DIS);
        push     = push_req && (!full || pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = rx_byte_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CW'(1);
            2'b01:   fcnt_d = fcnt_q - CW'(1);
            default: fcnt_d = fcnt_q;
        endcase

        ovr_d  = (push_req && full && !pop) || (ovr_q && !err_clr_i);
        ferr_d = (rx_vld_i && rx_ferr_i && (state_q != ST_DIS)) || (ferr_q && !err_clr_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rx_en_o    = rx_en_q;
    assign os_tick_o  = tick_q;
    assign rd_vld_o   = (fcnt_q != '0);
    assign rd_data_o  = rd_vld_o ? mem_q[rd_ptr_q] : '0;
    assign fifo_cnt_o = fcnt_q;
    assign ovr_err_o  = ovr_q;
    assign ferr_o     = ferr_q;

endmodule
